// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier arbiter slice.
package mult_arb_pkg;

    // Arbiter FSM: accept a request, compute for one cycle, present the product.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Upper bound on the number of requesters sharing one multiplier.
    localparam int unsigned MAX_REQ = 4;

    // Width of a requester index (owner register and round-robin pointer).
    function automatic int unsigned owner_w(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/multiplicador.sv
// Unsigned shift-and-add array multiplier. Exposes the low 2N-1 bits as the
// sum vector and the top bit as the final carry out of the adder chain.
module multiplicador #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-2:0] s,
    output logic           c_out
);

    logic [2*N-1:0] acc;

    // Accumulate one shifted copy of a per set bit of b.
    always_comb begin
        acc = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (b[i]) begin
                acc = acc + ({{N{1'b0}}, a} << i);
            end
        end
    end

    assign s     = acc[2*N-2:0];
    assign c_out = acc[2*N-1];

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first valid requester at or after ptr,
// wrapping modulo NUM_REQ, wins.
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned OW      = owner_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [OW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [OW-1:0]      idx,
    output logic               any
);

    // Walk the requesters starting at ptr; the first valid one is granted.
    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            j = (int'(ptr) + off) % NUM_REQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = OW'(j);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one combinational multiplier between NUM_REQ
// requesters. Operands and product are registered; one transaction is in
// flight at a time (IDLE -> CALC -> RESP).
// Optional: define MULT_ARBITER_STATS_EN to add per-requester saturating
// 8-bit grant counters on the grant_count output.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0][N-1:0]  req_a,
    input  logic [NUM_REQ-1:0][N-1:0]  req_b,
    output logic [NUM_REQ-1:0]         resp_valid,
    input  logic [NUM_REQ-1:0]         resp_ready,
    output logic [2*N-1:0]             resp_s,
    output logic                       busy
`ifdef MULT_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ-1:0][7:0]    grant_count
`endif
);

    localparam int unsigned OW = owner_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
        $error("mult_arbiter: NUM_REQ must lie in 2..MAX_REQ");
    end

    state_t         state_q, state_d;
    logic [OW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [OW-1:0]  owner_q, owner_d;
    logic [N-1:0]   op_a_q, op_a_d;
    logic [N-1:0]   op_b_q, op_b_d;
    logic [2*N-1:0] res_q, res_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [OW-1:0]      pick_idx;
    logic               pick_any;
    logic               take;
    logic [2*N-2:0]     mul_s;
    logic               mul_c;
    logic [OW-1:0]      ptr_after_owner;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OW      (OW)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // The multiplier only ever sees the registered operands.
    multiplicador #(
        .N (N)
    ) u_mult (
        .a     (op_a_q),
        .b     (op_b_q),
        .s     (mul_s),
        .c_out (mul_c)
    );

    // A request handshake can only happen in IDLE, where ready mirrors the pick.
    assign take = (state_q == IDLE) && pick_any;

    // Pointer moves just past the requester just served so others get a turn.
    assign ptr_after_owner = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Next-state, datapath capture and handshake outputs.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_d      = res_q;
        req_ready  = '0;
        resp_valid = '0;
        resp_s     = '0;
        busy       = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = pick_grant;
                if (take) begin
                    op_a_d  = req_a[pick_idx];
                    op_b_d  = req_b[pick_idx];
                    owner_d = pick_idx;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy     = 1'b1;
                res_d    = {mul_c, mul_s};
                rr_ptr_d = ptr_after_owner;
                state_d  = RESP;
            end
            RESP: begin
                busy                = 1'b1;
                resp_valid[owner_q] = 1'b1;
                resp_s              = res_q;
                // Only the owner's consumer can complete the response.
                if (resp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
        end
    end

`ifdef MULT_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][7:0] cnt_q;

    // Per-requester grant counters, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (take && pick_grant[i] && (cnt_q[i] != 8'hFF)) begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_mult_arbiter;

    localparam int N       = 4;
    localparam int NUM_REQ = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b1;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0][N-1:0] req_a;
    logic [NUM_REQ-1:0][N-1:0] req_b;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [2*N-1:0]            resp_s;
    logic                      busy;
`ifdef MULT_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][7:0]   grant_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int idx;
        int a;
        int b;
        int exp_s;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    mult_arbiter #(
        .N       (N),
        .NUM_REQ (NUM_REQ)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_s      (resp_s),
        .busy        (busy)
`ifdef MULT_ARBITER_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    // Requester protocol: operands stay put while a request waits for ready.
    logic [NUM_REQ-1:0]        hold_q = '0;
    logic [NUM_REQ-1:0][N-1:0] a_q, b_q;
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_n && hold_q[i] && req_valid[i]) begin
                assert (req_a[i] == a_q[i] && req_b[i] == b_q[i])
                    else $error("FAIL operand_hold req%0d", i);
            end
        end
        hold_q <= req_valid & ~req_ready;
        a_q    <= req_a;
        b_q    <= req_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // One isolated transaction on requester idx, with exact cycle timing.
    task automatic run_single(input int idx, input int a, input int b, input int exp_s);
        req_valid[idx] = 1'b1;
        req_a[idx]     = N'(a);
        req_b[idx]     = N'(b);
        #1;
        check("grant_ready", 32'(req_ready), 32'(1 << idx));
        check("idle_busy", 32'(busy), 32'd0);
        tick();
        req_valid[idx] = 1'b0;
        #1;
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_no_resp", 32'(resp_valid), 32'd0);
        tick();
        #1;
        check("resp_valid", 32'(resp_valid), 32'(1 << idx));
        check("resp_s", 32'(resp_s), 32'(exp_s));
        check("resp_busy", 32'(busy), 32'd1);
        resp_ready[idx] = 1'b1;
        tick();
        resp_ready[idx] = 1'b0;
        #1;
        check("back_idle", 32'(busy), 32'd0);
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (p + k) % NUM_REQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    initial begin
        vecs[0] = '{idx: 0, a: 3,  b: 5,  exp_s: 15};
        vecs[1] = '{idx: 1, a: 15, b: 15, exp_s: 225};
        vecs[2] = '{idx: 0, a: 0,  b: 9,  exp_s: 0};
        vecs[3] = '{idx: 1, a: 8,  b: 2,  exp_s: 16};
        vecs[4] = '{idx: 0, a: 12, b: 11, exp_s: 132};
        vecs[5] = '{idx: 1, a: 15, b: 1,  exp_s: 15};
        vecs[6] = '{idx: 0, a: 10, b: 13, exp_s: 130};

        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '0;
        #1;
        rst_n = 1'b0;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_s", 32'(resp_s), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        do_reset();

        // Directed vector table.
        for (int v = 0; v < 7; v++) begin
            run_single(vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].exp_s);
        end

        // Contention right after reset: req0 first, then req1, then back to req0.
        do_reset();
        resp_ready = '1;
        req_valid  = 2'b11;
        req_a[0] = 4'd2; req_b[0] = 4'd3;
        req_a[1] = 4'd4; req_b[1] = 4'd4;
        #1;
        check("cont_first_grant", 32'(req_ready), 32'b01);
        tick();
        req_a[0] = 4'd1; req_b[0] = 4'd1;
        #1;
        check("cont_calc_ready", 32'(req_ready), 32'd0);
        tick();
        #1;
        check("cont_resp0_valid", 32'(resp_valid), 32'b01);
        check("cont_resp0_s", 32'(resp_s), 32'd6);
        check("cont_resp_ready", 32'(req_ready), 32'd0);
        tick();
        #1;
        check("cont_second_grant", 32'(req_ready), 32'b10);
        tick();
        req_valid[1] = 1'b0;
        tick();
        #1;
        check("cont_resp1_valid", 32'(resp_valid), 32'b10);
        check("cont_resp1_s", 32'(resp_s), 32'd16);
        tick();
        #1;
        check("cont_third_grant", 32'(req_ready), 32'b01);
        tick();
        req_valid[0] = 1'b0;
        tick();
        #1;
        check("cont_resp2_s", 32'(resp_s), 32'd1);
        tick();
        resp_ready = '0;
        #1;

        // Backpressure: owner stalls, non-owner ready and pending request ignored.
        req_valid[0] = 1'b1;
        req_a[0] = 4'd5; req_b[0] = 4'd6;
        #1;
        check("bp_grant", 32'(req_ready), 32'b01);
        tick();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1;
        req_a[1] = 4'd3; req_b[1] = 4'd3;
        #1;
        check("bp_calc_ready", 32'(req_ready), 32'd0);
        tick();
        resp_ready[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_hold_valid", 32'(resp_valid), 32'b01);
            check("bp_hold_s", 32'(resp_s), 32'd30);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 2'b01;
        #1;
        check("bp_still_valid", 32'(resp_valid), 32'b01);
        tick();
        resp_ready = '0;
        #1;
        check("bp_released", 32'(resp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'b10);
        tick();
        req_valid[1] = 1'b0;
        tick();
        #1;
        check("bp_resp1_s", 32'(resp_s), 32'd9);
        resp_ready[1] = 1'b1;
        tick();
        resp_ready = '0;
        #1;

        // Reset during CALC of 7x9: transaction vanishes, outputs clear at once.
        resp_ready = '1;
        req_valid[0] = 1'b1;
        req_a[0] = 4'd7; req_b[0] = 4'd9;
        #1;
        check("rm_grant", 32'(req_ready), 32'b01);
        tick();
        req_valid[0] = 1'b0;
        #1;
        check("rm_calc_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rm_async_busy", 32'(busy), 32'd0);
        check("rm_async_valid", 32'(resp_valid), 32'd0);
        check("rm_async_ready", 32'(req_ready), 32'd0);
        check("rm_async_s", 32'(resp_s), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            #1;
            check("rm_no_resp", 32'(resp_valid), 32'd0);
        end
        resp_ready = '0;
        run_single(0, 1, 1, 1);

        // Randomized traffic against a transaction-level model.
        begin
            int ptr;
            bit outst;
            int own;
            int age;
            int prod;
            int g;
            int gcnt[NUM_REQ];
            logic [NUM_REQ-1:0] exp_rdy;
            logic [NUM_REQ-1:0] exp_rv;
            logic [NUM_REQ-1:0] acc_last;

            do_reset();
            ptr = 0; outst = 0; own = 0; age = 0; prod = 0;
            acc_last = '0;
            for (int i = 0; i < NUM_REQ; i++) gcnt[i] = 0;

            for (int cyc = 0; cyc < 2000; cyc++) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && acc_last[i]) begin
                        req_valid[i] = 1'b0;
                    end else if (req_valid[i]) begin
                        if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
                    end else if ($urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        req_a[i]     = N'($urandom_range(0, 15));
                        req_b[i]     = N'($urandom_range(0, 15));
                    end
                end
                resp_ready = NUM_REQ'($urandom);
                #1;

                exp_rdy = '0;
                exp_rv  = '0;
                g       = -1;
                if (!outst) begin
                    g = pick(req_valid, ptr);
                    if (g >= 0) exp_rdy[g] = 1'b1;
                end
                if (outst && age >= 2) exp_rv[own] = 1'b1;

                check("rand_req_ready", 32'(req_ready), 32'(exp_rdy));
                check("rand_resp_valid", 32'(resp_valid), 32'(exp_rv));
                check("rand_busy", 32'(busy), 32'(outst));
                if (exp_rv != '0) check("rand_resp_s", 32'(resp_s), 32'(prod));
                acc_last = exp_rdy;

                if (outst) begin
                    if (age >= 2 && resp_ready[own]) outst = 0;
                    else age++;
                end else if (g >= 0) begin
                    outst = 1;
                    own   = g;
                    age   = 1;
                    prod  = int'(req_a[g]) * int'(req_b[g]);
                    ptr   = (g + 1) % NUM_REQ;
                    if (gcnt[g] < 255) gcnt[g]++;
                end
                tick();
            end
`ifdef MULT_ARBITER_STATS_EN
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                check("rand_grant_count", 32'(grant_count[i]), 32'(gcnt[i]));
            end
`endif
            req_valid  = '0;
            resp_ready = '0;
        end

`ifdef MULT_ARBITER_STATS_EN
        // Grant counters: 3 + 2 transactions, then saturation at 255.
        do_reset();
        check("stats_rst0", 32'(grant_count[0]), 32'd0);
        check("stats_rst1", 32'(grant_count[1]), 32'd0);
        for (int k = 0; k < 3; k++) run_single(0, 2, 2, 4);
        for (int k = 0; k < 2; k++) run_single(1, 3, 2, 6);
        check("stats_cnt0", 32'(grant_count[0]), 32'd3);
        check("stats_cnt1", 32'(grant_count[1]), 32'd2);
        for (int k = 0; k < 255; k++) run_single(0, 1, 2, 2);
        check("stats_sat0", 32'(grant_count[0]), 32'd255);
        check("stats_keep1", 32'(grant_count[1]), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
